// File: rtl/apb_master_param.sv
// APB master with one outstanding transfer, upper-address slave decode and
// an ACCESS-phase timeout. Back-to-back requests go straight from ACCESS to SETUP.
module apb_master_param #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             transfer,
  input  logic                             READ_WRITE,
  input  logic [ADDR_WIDTH-1:0]            apb_write_paddr,
  input  logic [DATA_WIDTH-1:0]            apb_write_data,
  input  logic [ADDR_WIDTH-1:0]            apb_read_paddr,
  output logic [DATA_WIDTH-1:0]            apb_read_data_out,
  output logic                             PSLVERR,
  output logic                             xfer_done,
  output logic [NUM_SLAVES-1:0]            PSEL_o,
  output logic                             PENABLE_o,
  output logic                             PWRITE_o,
  output logic [ADDR_WIDTH-1:0]            PADDR_o,
  output logic [DATA_WIDTH-1:0]            PWDATA_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA_i,
  input  logic [NUM_SLAVES-1:0]            PREADY_i,
  input  logic [NUM_SLAVES-1:0]            PSLVERR_i
);

  localparam int SEL_W = $clog2(NUM_SLAVES);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [NUM_SLAVES-1:0] SEL_ONE = NUM_SLAVES'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_read;
  logic [CNT_W-1:0]      r_cnt;

  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic [NUM_SLAVES-1:0] w_req_psel;
  logic [SEL_W-1:0]      w_sel;
  logic                  w_ready;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] w_prdata [NUM_SLAVES];

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_rdata_split
    assign w_prdata[g] = PRDATA_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Request decode from the live inputs, and response mux from the slave held on PADDR_o.
  always_comb begin
    w_req_addr = READ_WRITE ? apb_read_paddr : apb_write_paddr;
    w_req_psel = SEL_ONE << w_req_addr[ADDR_WIDTH-1 -: SEL_W];
    w_sel      = PADDR_o[ADDR_WIDTH-1 -: SEL_W];
    w_ready    = PREADY_i[w_sel];
    w_err      = PSLVERR_i[w_sel];
    w_rdata    = w_prdata[w_sel];
  end

  // Transfer FSM with all bus and status outputs registered.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state           <= ST_IDLE;
      r_read            <= 1'b0;
      r_cnt             <= {CNT_W{1'b0}};
      apb_read_data_out <= {DATA_WIDTH{1'b0}};
      PSLVERR           <= 1'b0;
      xfer_done         <= 1'b0;
      PSEL_o            <= {NUM_SLAVES{1'b0}};
      PENABLE_o         <= 1'b0;
      PWRITE_o          <= 1'b0;
      PADDR_o           <= {ADDR_WIDTH{1'b0}};
      PWDATA_o          <= {DATA_WIDTH{1'b0}};
    end else begin
      xfer_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (transfer) begin
            r_state   <= ST_SETUP;
            r_read    <= READ_WRITE;
            r_cnt     <= {CNT_W{1'b0}};
            PSEL_o    <= w_req_psel;
            PENABLE_o <= 1'b0;
            PWRITE_o  <= ~READ_WRITE;
            PADDR_o   <= w_req_addr;
            PWDATA_o  <= apb_write_data;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          r_state   <= ST_ACCESS;
          PENABLE_o <= 1'b1;
        end
        ST_ACCESS: begin
          // Ready wins over the timeout when both land on the same cycle.
          if (w_ready) begin
            xfer_done <= 1'b1;
            PSLVERR   <= w_err;
            if (r_read) begin
              apb_read_data_out <= w_err ? {DATA_WIDTH{1'b0}} : w_rdata;
            end
            if (transfer) begin
              r_state   <= ST_SETUP;
              r_read    <= READ_WRITE;
              r_cnt     <= {CNT_W{1'b0}};
              PSEL_o    <= w_req_psel;
              PENABLE_o <= 1'b0;
              PWRITE_o  <= ~READ_WRITE;
              PADDR_o   <= w_req_addr;
              PWDATA_o  <= apb_write_data;
            end else begin
              r_state   <= ST_IDLE;
              PSEL_o    <= {NUM_SLAVES{1'b0}};
              PENABLE_o <= 1'b0;
              PWRITE_o  <= 1'b0;
              PADDR_o   <= {ADDR_WIDTH{1'b0}};
              PWDATA_o  <= {DATA_WIDTH{1'b0}};
            end
          end else if (r_cnt == CNT_LAST) begin
            xfer_done <= 1'b1;
            PSLVERR   <= 1'b1;
            if (r_read) begin
              apb_read_data_out <= {DATA_WIDTH{1'b0}};
            end
            r_state   <= ST_IDLE;
            PSEL_o    <= {NUM_SLAVES{1'b0}};
            PENABLE_o <= 1'b0;
            PWRITE_o  <= 1'b0;
            PADDR_o   <= {ADDR_WIDTH{1'b0}};
            PWDATA_o  <= {DATA_WIDTH{1'b0}};
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          PSEL_o    <= {NUM_SLAVES{1'b0}};
          PENABLE_o <= 1'b0;
          PWRITE_o  <= 1'b0;
          PADDR_o   <= {ADDR_WIDTH{1'b0}};
          PWDATA_o  <= {DATA_WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_param.sv
// Directed plus randomized bench for apb_master_param; expected results come
// from transfer-level rules (wait count vs. timeout, slave = top address bit).
module tb_apb_master_param;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int NS = 2;
  localparam int TO = 16;

  logic           PCLK = 1'b0;
  logic           PRESET = 1'b0;
  logic           transfer = 1'b0;
  logic           READ_WRITE = 1'b0;
  logic [AW-1:0]  apb_write_paddr = '0;
  logic [DW-1:0]  apb_write_data = '0;
  logic [AW-1:0]  apb_read_paddr = '0;
  logic [DW-1:0]  apb_read_data_out;
  logic           PSLVERR;
  logic           xfer_done;
  logic [NS-1:0]  PSEL_o;
  logic           PENABLE_o;
  logic           PWRITE_o;
  logic [AW-1:0]  PADDR_o;
  logic [DW-1:0]  PWDATA_o;
  logic [NS*DW-1:0] PRDATA_i = '0;
  logic [NS-1:0]  PREADY_i = '0;
  logic [NS-1:0]  PSLVERR_i = '0;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_rd = '0;
  logic          exp_err = 1'b0;

  apb_master_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .READ_WRITE(READ_WRITE),
    .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
    .apb_read_paddr(apb_read_paddr), .apb_read_data_out(apb_read_data_out),
    .PSLVERR(PSLVERR), .xfer_done(xfer_done), .PSEL_o(PSEL_o), .PENABLE_o(PENABLE_o),
    .PWRITE_o(PWRITE_o), .PADDR_o(PADDR_o), .PWDATA_o(PWDATA_o),
    .PRDATA_i(PRDATA_i), .PREADY_i(PREADY_i), .PSLVERR_i(PSLVERR_i)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave index is the address divided by half the address space.
  function automatic int slave_of(input logic [AW-1:0] addr);
    return int'(addr) / (2 ** (AW - 1));
  endfunction

  task automatic noise_req();
    READ_WRITE      = 1'($urandom);
    apb_write_paddr = AW'($urandom);
    apb_read_paddr  = AW'($urandom);
    apb_write_data  = DW'($urandom);
  endtask

  task automatic start_req(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    noise_req();
    transfer   = 1'b1;
    READ_WRITE = rw;
    if (rw) apb_read_paddr = addr;
    else    apb_write_paddr = addr;
    apb_write_data = wd;
  endtask

  task automatic drive_slaves(input int slv, input bit rdy, input logic serr, input logic [DW-1:0] rd);
    for (int s = 0; s < NS; s++) begin
      if (s == slv) begin
        PREADY_i[s]          = rdy;
        PSLVERR_i[s]         = rdy ? serr : 1'($urandom);
        PRDATA_i[s*DW +: DW] = rdy ? rd : DW'($urandom);
      end else begin
        PREADY_i[s]          = 1'($urandom);
        PSLVERR_i[s]         = 1'($urandom);
        PRDATA_i[s*DW +: DW] = DW'($urandom);
      end
    end
  endtask

  // One transfer: slave becomes ready after w wait cycles (w >= TO means never).
  task automatic run_txn(input bit at_setup, input logic rw, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int w, input logic serr,
                         input logic [DW-1:0] rd, input bit chain, input logic nrw,
                         input logic [AW-1:0] naddr, input logic [DW-1:0] nwd,
                         output bit chained);
    int  slv = slave_of(addr);
    int  acc = 0;
    bit  done = 1'b0;
    bit  abort = (w >= TO);
    if (!at_setup) @(negedge PCLK);
    chk("setup_psel", 32'(PSEL_o), 32'(1 << slv));
    chk("setup_penable", 32'(PENABLE_o), 32'd0);
    chk("setup_pwrite", 32'(PWRITE_o), 32'(!rw));
    chk("setup_paddr", 32'(PADDR_o), 32'(addr));
    chk("setup_pwdata", 32'(PWDATA_o), 32'(wd));
    transfer = 1'b0;
    noise_req();
    drive_slaves(slv, 1'b0, 1'b0, 8'h00);
    PREADY_i = 2'b11;
    @(negedge PCLK);
    for (int cyc = 1; cyc <= TO; cyc++) begin
      chk("access_penable", 32'(PENABLE_o), 32'd1);
      chk("access_psel", 32'(PSEL_o), 32'(1 << slv));
      chk("access_done_low", 32'(xfer_done), 32'd0);
      acc++;
      done = (cyc == w + 1) || (cyc == TO);
      drive_slaves(slv, cyc == w + 1, serr, rd);
      if (done && chain) start_req(nrw, naddr, nwd);
      else begin
        noise_req();
        transfer = 1'b0;
      end
      @(negedge PCLK);
      if (done) break;
    end
    chk("access_cycles", 32'(acc), 32'(abort ? TO : w + 1));
    if (abort) begin
      exp_err = 1'b1;
      if (rw) exp_rd = '0;
    end else begin
      exp_err = serr;
      if (rw) exp_rd = serr ? 8'h00 : rd;
    end
    chk("done_pulse", 32'(xfer_done), 32'd1);
    chk("pslverr", 32'(PSLVERR), 32'(exp_err));
    chk("read_data", 32'(apb_read_data_out), 32'(exp_rd));
    chained = chain && !abort;
    PREADY_i = '0;
    if (!chained) begin
      transfer = 1'b0;
      chk("idle_psel", 32'(PSEL_o), 32'd0);
      chk("idle_penable", 32'(PENABLE_o), 32'd0);
      chk("idle_pwrite", 32'(PWRITE_o), 32'd0);
      chk("idle_paddr", 32'(PADDR_o), 32'd0);
      chk("idle_pwdata", 32'(PWDATA_o), 32'd0);
      @(negedge PCLK);
      chk("done_single", 32'(xfer_done), 32'd0);
      chk("idle_hold_psel", 32'(PSEL_o), 32'd0);
      chk("hold_pslverr", 32'(PSLVERR), 32'(exp_err));
      chk("hold_read_data", 32'(apb_read_data_out), 32'(exp_rd));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_psel"}, 32'(PSEL_o), 32'd0);
    chk({tag, "_penable"}, 32'(PENABLE_o), 32'd0);
    chk({tag, "_pwrite"}, 32'(PWRITE_o), 32'd0);
    chk({tag, "_paddr"}, 32'(PADDR_o), 32'd0);
    chk({tag, "_pwdata"}, 32'(PWDATA_o), 32'd0);
    chk({tag, "_rdata"}, 32'(apb_read_data_out), 32'd0);
    chk({tag, "_pslverr"}, 32'(PSLVERR), 32'd0);
    chk({tag, "_done"}, 32'(xfer_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ch;
    logic crw, nrw;
    logic [AW-1:0] caddr, naddr;
    logic [DW-1:0] cwd, nwd;
    bit st;
    int w;

    // Reset with a request already pending: nothing may be captured.
    #1 PRESET = 1'b1;
    transfer = 1'b1;
    apb_write_paddr = 9'h1AB;
    apb_write_data = 8'hEE;
    #1 chk_all_zero("reset");
    @(negedge PCLK);
    @(negedge PCLK);
    chk_all_zero("reset_hold");
    PRESET = 1'b0;
    transfer = 1'b0;

    // Write, slave 0, zero wait.
    start_req(1'b0, 9'h012, 8'hA5);
    run_txn(1'b0, 1'b0, 9'h012, 8'hA5, 0, 1'b0, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00, ch);
    // Read, slave 1, two wait states.
    start_req(1'b1, 9'h1F0, 8'h00);
    run_txn(1'b0, 1'b1, 9'h1F0, 8'h00, 2, 1'b0, 8'h3C, 1'b0, 1'b0, 9'h000, 8'h00, ch);
    // Back-to-back write then read.
    start_req(1'b0, 9'h005, 8'h77);
    run_txn(1'b0, 1'b0, 9'h005, 8'h77, 1, 1'b0, 8'h00, 1'b1, 1'b1, 9'h105, 8'h00, ch);
    run_txn(1'b1, 1'b1, 9'h105, 8'h00, 0, 1'b0, 8'h5A, 1'b0, 1'b0, 9'h000, 8'h00, ch);
    // Write with slave error leaves read data untouched.
    start_req(1'b0, 9'h133, 8'h21);
    run_txn(1'b0, 1'b0, 9'h133, 8'h21, 1, 1'b1, 8'h99, 1'b0, 1'b0, 9'h000, 8'h00, ch);
    // Read with slave error.
    start_req(1'b1, 9'h040, 8'h00);
    run_txn(1'b0, 1'b1, 9'h040, 8'h00, 0, 1'b1, 8'hFF, 1'b0, 1'b0, 9'h000, 8'h00, ch);
    // Ready on the timeout cycle completes normally.
    start_req(1'b1, 9'h0C4, 8'h00);
    run_txn(1'b0, 1'b1, 9'h0C4, 8'h00, TO - 1, 1'b0, 8'h81, 1'b0, 1'b0, 9'h000, 8'h00, ch);
    // Timeout abort with transfer held: must still return to IDLE.
    start_req(1'b1, 9'h1C4, 8'h00);
    run_txn(1'b0, 1'b1, 9'h1C4, 8'h00, TO + 3, 1'b0, 8'h42, 1'b1, 1'b0, 9'h0AA, 8'h55, ch);

    // Reset during ACCESS with the slave ready: no completion may appear.
    start_req(1'b1, 9'h133, 8'h00);
    @(negedge PCLK);
    transfer = 1'b0;
    @(negedge PCLK);
    chk("pre_reset_penable", 32'(PENABLE_o), 32'd1);
    PREADY_i = 2'b11;
    #1 PRESET = 1'b1;
    #1 chk_all_zero("async_reset");
    @(negedge PCLK);
    PRESET = 1'b0;
    PREADY_i = '0;
    exp_rd = '0;
    exp_err = 1'b0;
    @(negedge PCLK);
    chk_all_zero("post_reset");
    start_req(1'b1, 9'h101, 8'h00);
    run_txn(1'b0, 1'b1, 9'h101, 8'h00, 1, 1'b0, 8'hC3, 1'b0, 1'b0, 9'h000, 8'h00, ch);

    // Randomized transfers, optionally chained.
    nrw = 1'($urandom); naddr = AW'($urandom); nwd = DW'($urandom);
    st = 1'b0;
    for (int i = 0; i < 30; i++) begin
      crw = nrw; caddr = naddr; cwd = nwd;
      if (!st) start_req(crw, caddr, cwd);
      nrw = 1'($urandom); naddr = AW'($urandom); nwd = DW'($urandom);
      w = ($urandom_range(0, 7) == 0) ? TO + int'($urandom_range(0, 3)) : int'($urandom_range(0, 4));
      run_txn(st, crw, caddr, cwd, w, 1'($urandom), DW'($urandom),
              (i < 29) && ($urandom_range(0, 1) == 1), nrw, naddr, nwd, ch);
      st = ch;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_param.md
APB_MASTER_PARAM -- requirements
Module: apb_master_param

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_WIDTH, 9, PADDR width; the upper $clog2(NUM_SLAVES) bits select the slave.
- DATA_WIDTH, 8, data width.
- NUM_SLAVES, 2, slave count; power of 2, minimum 2.
- TIMEOUT, 16, maximum ACCESS cycles without PREADY; minimum 2.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. One clock; reset is asynchronous and active-high.
- PCLK, in, 1, clock; all logic on the rising edge.
- PRESET, in, 1, asynchronous active-high reset.
- transfer, in, 1, transfer request.
- READ_WRITE, in, 1, direction; 1=read, 0=write.
- apb_write_paddr, in, ADDR_WIDTH, write address.
- apb_write_data, in, DATA_WIDTH, write data.
- apb_read_paddr, in, ADDR_WIDTH, read address.
- apb_read_data_out, out, DATA_WIDTH, last read data.
- PSLVERR, out, 1, completion status of the last transfer.
- xfer_done, out, 1, one-cycle completion pulse.
- PSEL_o, out, NUM_SLAVES, one-hot slave select.
- PENABLE_o, out, 1, APB enable.
- PWRITE_o, out, 1, APB write.
- PADDR_o, out, ADDR_WIDTH, APB address.
- PWDATA_o, out, DATA_WIDTH, APB write data.
- PRDATA_i, in, NUM_SLAVES*DATA_WIDTH, slave read data; slave k occupies slice k.
- PREADY_i, in, NUM_SLAVES, per-slave ready.
- PSLVERR_i, in, NUM_SLAVES, per-slave error.

Function
REQ-003 The FSM SHALL have three states: IDLE, SETUP and ACCESS; every output is registered.
REQ-004 IDLE with transfer=1 at a PCLK edge SHALL capture request fields and go to SETUP. Captured fields:
- READ_WRITE;
- the address: apb_read_paddr if read, else apb_write_paddr;
- apb_write_data.
REQ-005 IDLE with transfer=0 SHALL remain in IDLE.
REQ-006 In IDLE, PSEL_o, PENABLE_o, PWRITE_o, PADDR_o and PWDATA_o SHALL all be 0.
REQ-007 SETUP drive (exactly one cycle, then ACCESS):
- PSEL_o[k]=1 only for k = the upper $clog2(NUM_SLAVES) bits of the captured address;
- PENABLE_o=0;
- PWRITE_o = !READ_WRITE;
- PADDR_o and PWDATA_o = captured values.
REQ-008 ACCESS SHALL hold the SETUP values with PENABLE_o=1 and wait for PREADY_i[k].
REQ-009 An ACCESS cycle with PREADY_i[k]=1 SHALL complete the transfer:
- xfer_done=1 for the next cycle;
- PSLVERR = PSLVERR_i[k];
- on a read with PSLVERR_i[k]=0, apb_read_data_out = PRDATA_i slice k;
- on a read with PSLVERR_i[k]=1, apb_read_data_out = 0;
- on a write, apb_read_data_out is unchanged.
REQ-010 On completion, the next state SHALL be SETUP with a fresh capture per REQ-004 if transfer=1 (back-to-back, no IDLE cycle); otherwise IDLE.
REQ-011 A timeout counter SHALL clear on SETUP entry and increment each ACCESS cycle without PREADY_i[k].
REQ-012 When the counter reaches TIMEOUT-1 with PREADY_i[k]=0, the block SHALL abort the transfer:
- PSLVERR=1 and xfer_done=1;
- apb_read_data_out = 0 if read;
- go to IDLE regardless of transfer.
REQ-013 PREADY_i[k] arriving on the timeout cycle SHALL take priority over the timeout (normal completion).
REQ-014 PREADY_i/PSLVERR_i/PRDATA_i of non-selected slaves SHALL be ignored.
REQ-015 PSLVERR and apb_read_data_out SHALL hold their values until the next completion.
REQ-016 Request inputs SHALL be ignored outside IDLE and outside the completion cycle.
REQ-017 Minimum transfer latency SHALL be 3 edges: capture, SETUP, ACCESS with PREADY=1. xfer_done is visible after the third edge.

Reset
REQ-018 PRESET=1 SHALL immediately force, without waiting for a PCLK edge:
- FSM = IDLE and timeout counter = 0;
- all outputs = 0, including apb_read_data_out, PSLVERR and xfer_done.
REQ-019 A transfer in progress when PRESET asserts SHALL be discarded with no xfer_done.
REQ-020 The first transfer SHALL be captured no earlier than the first edge after PRESET deasserts.

Verification
REQ-021 Write, slave 0, zero wait:
- stimulus: transfer=1 for one cycle, READ_WRITE=0, apb_write_paddr=0x012, apb_write_data=0xA5;
- response: SETUP has PSEL_o=2'b01, PADDR_o=0x012, PWDATA_o=0xA5, PWRITE_o=1; then ACCESS; xfer_done=1, PSLVERR=0.
REQ-022 Read, slave 1, two wait states:
- stimulus: apb_read_paddr=0x1F0, PRDATA_i slave 1=0x3C, PREADY_i[1] on the 3rd ACCESS cycle;
- response: PSEL_o=2'b10, PENABLE_o high 3 cycles, apb_read_data_out=0x3C, PSLVERR=0.
REQ-023 Back-to-back:
- stimulus: transfer held 1 across a write to 0x005 then a read from 0x105;
- response: SETUP follows ACCESS directly with no IDLE cycle; xfer_done pulses twice.
REQ-024 Slave error:
- stimulus: read with PREADY_i[0]=1, PSLVERR_i[0]=1;
- response: PSLVERR=1, apb_read_data_out=0x00.
REQ-025 Timeout:
- stimulus: PREADY_i held 0 with TIMEOUT=16;
- response: abort after 16 ACCESS cycles, PSLVERR=1, xfer_done=1, FSM in IDLE.
REQ-026 Reset mid-ACCESS:
- stimulus: PRESET pulsed during ACCESS;
- response: outputs 0 immediately, no xfer_done; the next transfer proceeds normally.
